// File: rtl/mesh_arb_pkg.sv
// ---------------------------------------------------------------------------
// mesh_arb_pkg
// Shared definitions for the mesh output-link arbiter: packet field offsets,
// the broadcast next-jump code and the output-register state type.
// Packet layout (MSB first): Nxtjp[8] | row[4] | colum[4] | mode[1] | payload
// ---------------------------------------------------------------------------
package mesh_arb_pkg;

    localparam int PCKG_SZ     = 40;

    localparam int NXTJP_MSB   = PCKG_SZ - 1;
    localparam int NXTJP_LSB   = PCKG_SZ - 8;
    localparam int ROW_MSB     = PCKG_SZ - 9;
    localparam int ROW_LSB     = PCKG_SZ - 12;
    localparam int COL_MSB     = PCKG_SZ - 13;
    localparam int COL_LSB     = PCKG_SZ - 16;
    localparam int MODE_BIT    = PCKG_SZ - 17;
    localparam int PAYLOAD_MSB = PCKG_SZ - 18;

    // Next-jump value marking a broadcast packet. The arbiter forwards it
    // like any other packet; it is kept here for neighbouring blocks.
    localparam logic [7:0] BDCST = 8'hFF;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

    function automatic logic is_bdcst(input logic [PCKG_SZ-1:0] pkt);
        return pkt[NXTJP_MSB:NXTJP_LSB] == BDCST;
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// ---------------------------------------------------------------------------
// rr_arb_pick
// Combinational round-robin pick: finds the first set bit of i_req searching
// circularly from i_ptr+1.
//   i_req      N_IN   request vector
//   i_ptr      IDX_W  index of the previous winner
//   o_gnt      N_IN   one-hot grant (zero when nothing requests)
//   o_gnt_idx  IDX_W  winner index (0 when nothing requests)
//   o_any      1      at least one request
// ---------------------------------------------------------------------------
module rr_arb_pick #(
    parameter int N_IN  = 5,
    parameter int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic [N_IN-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_IN-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_any
);
    import mesh_arb_pkg::*;

    logic [IDX_W-1:0]  w_start;
    logic [2*N_IN-1:0] w_dbl;
    logic [2*N_IN-1:0] w_rot;
    logic [IDX_W-1:0]  w_off;
    logic [IDX_W:0]    w_sum;

    always_comb begin
        // Search starts one past the last winner, wrapping at N_IN.
        w_start = (i_ptr == IDX_W'(N_IN - 1)) ? '0 : i_ptr + 1'b1;
        // Two copies side by side let a plain right shift act as a rotate.
        w_dbl   = {i_req, i_req};
        w_rot   = w_dbl >> w_start;
        // Descending scan so the lowest set offset is the last one written.
        w_off   = '0;
        for (int j = N_IN - 1; j >= 0; j--) begin
            if (w_rot[j]) w_off = IDX_W'(j);
        end
        w_sum   = {1'b0, w_start} + {1'b0, w_off};
        if (w_sum >= (IDX_W+1)'(N_IN)) w_sum = w_sum - (IDX_W+1)'(N_IN);
        o_any     = |i_req;
        o_gnt_idx = o_any ? w_sum[IDX_W-1:0] : '0;
        o_gnt     = '0;
        for (int i = 0; i < N_IN; i++) begin
            o_gnt[i] = o_any && (o_gnt_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/mesh_out_arbiter.sv
// ---------------------------------------------------------------------------
// mesh_out_arbiter
// Round-robin arbiter sharing one router output link among N_IN show-ahead
// input FIFOs. One packet is popped per grant into a one-entry output
// register; a full register can reload on the same edge it is consumed.
//   i_clk        clock, rising edge
//   i_reset      asynchronous reset, active low
//   i_en         arbitration enable (output register still drains when 0)
//   i_in_mask    N_IN, 1 excludes input i from arbitration
//   i_in_pndng   N_IN, FIFO i non-empty
//   i_in_data    N_IN*pckg_sz, head word of FIFO i at [i*pckg_sz +: pckg_sz]
//   o_in_pop     N_IN, one-hot pop to the granted FIFO (combinational)
//   o_out_pndng  output register valid
//   o_out_data   output register contents
//   i_out_pop    downstream consumes o_out_data this cycle
//   o_gnt_id     index of the last granted input
//   o_pkt_cnt    packets granted since reset, wrapping
//   o_stall_err  sticky: STALL_TO consecutive cycles valid without pop
// ---------------------------------------------------------------------------
module mesh_out_arbiter
    import mesh_arb_pkg::*;
#(
    parameter int N_IN     = 5,
    parameter int pckg_sz  = PCKG_SZ,
    parameter int STALL_TO = 64,
    parameter int CNT_W    = 16,
    localparam int GID_W   = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int SC_W    = $clog2(STALL_TO + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_en,
    input  logic [N_IN-1:0]         i_in_mask,
    input  logic [N_IN-1:0]         i_in_pndng,
    input  logic [N_IN*pckg_sz-1:0] i_in_data,
    output logic [N_IN-1:0]         o_in_pop,
    output logic                    o_out_pndng,
    output logic [pckg_sz-1:0]      o_out_data,
    input  logic                    i_out_pop,
    output logic [GID_W-1:0]        o_gnt_id,
    output logic [CNT_W-1:0]        o_pkt_cnt,
    output logic                    o_stall_err
);

    arb_state_e         r_state;
    logic [pckg_sz-1:0] r_data;
    logic [GID_W-1:0]   r_ptr;
    logic [GID_W-1:0]   r_gnt_id;
    logic [CNT_W-1:0]   r_pkt_cnt;
    logic [SC_W-1:0]    r_stall_cnt;
    logic               r_stall_err;

    logic [N_IN-1:0]    w_req;
    logic [N_IN-1:0]    w_gnt;
    logic [GID_W-1:0]   w_gnt_idx;
    logic               w_any;
    logic               w_full;
    logic               w_can_load;
    logic               w_stalled;
    logic [pckg_sz-1:0] w_sel_data;

    assign w_req  = i_in_pndng & ~i_in_mask;
    assign w_full = (r_state == FULL);

    rr_arb_pick #(
        .N_IN  (N_IN),
        .IDX_W (GID_W)
    ) u_pick (
        .i_req     (w_req),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    // i_reset in the term keeps in_pop low while reset is held, so no FIFO
    // loses a word that the cleared output register would never carry.
    assign w_can_load = i_reset & i_en & w_any & (~w_full | i_out_pop);
    assign o_in_pop   = w_can_load ? w_gnt : '0;
    assign w_sel_data = i_in_data[w_gnt_idx*pckg_sz +: pckg_sz];
    assign w_stalled  = w_full & ~i_out_pop;

    // Output register FSM. A pop on an EMPTY register is simply ignored.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= EMPTY;
            r_data    <= '0;
            r_ptr     <= GID_W'(N_IN - 1);
            r_gnt_id  <= '0;
            r_pkt_cnt <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_can_load) r_state <= FULL;
                end
                FULL: begin
                    if (i_out_pop && !w_can_load) r_state <= EMPTY;
                end
                default: r_state <= EMPTY;
            endcase
            if (w_can_load) begin
                r_data    <= w_sel_data;
                r_ptr     <= w_gnt_idx;
                r_gnt_id  <= w_gnt_idx;
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
        end
    end

    // Stall watchdog: counts consecutive held-but-unconsumed cycles and
    // saturates; the error flag latches on the cycle the count hits STALL_TO.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_stall_cnt <= '0;
            r_stall_err <= 1'b0;
        end else begin
            if (w_stalled) begin
                if (r_stall_cnt != SC_W'(STALL_TO)) r_stall_cnt <= r_stall_cnt + 1'b1;
                if (r_stall_cnt >= SC_W'(STALL_TO - 1)) r_stall_err <= 1'b1;
            end else begin
                r_stall_cnt <= '0;
            end
        end
    end

    assign o_out_pndng = w_full;
    assign o_out_data  = r_data;
    assign o_gnt_id    = r_gnt_id;
    assign o_pkt_cnt   = r_pkt_cnt;
    assign o_stall_err = r_stall_err;

endmodule

// File: doc/mesh_out_arbiter.md
Name: mesh_out_arbiter

Overview:
- Round-robin arbiter sharing one router output link among N_IN input FIFOs of a mesh_gnrtr node (N, S, E, W and local terminal).
- Pops one packet per grant from the winning FIFO using the mesh pndng/pop handshake.
- Holds the packet in a one-entry output register presented as pndng/data to the downstream link.
- Also provides per-input masking, a packet counter and a stall watchdog.

Parameters:
- N_IN, 5, number of requesting input FIFOs.
- pckg_sz, 40, packet width: Nxtjp[pckg_sz-1:pckg_sz-8], row[pckg_sz-9:pckg_sz-12], colum[pckg_sz-13:pckg_sz-16], mode[pckg_sz-17], payload[pckg_sz-18:0].
- STALL_TO, 64, consecutive cycles of out_pndng without out_pop before stall_err sets.
- CNT_W, 16, width of pkt_cnt.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous reset, active-low (0 = reset asserted).
- en  in  1  arbitration enable; 0 means no new grants, output register still drains.
- in_mask  in  N_IN  1 means input i is excluded from arbitration.
- in_pndng  in  N_IN  input FIFO i non-empty; show-ahead data valid.
- in_data  in  N_IN*pckg_sz  head word of FIFO i, slice i at [i*pckg_sz +: pckg_sz].
- in_pop  out  N_IN  one-hot pop strobe to the granted FIFO.
- out_pndng  out  1  output register valid.
- out_data  out  pckg_sz  output register contents.
- out_pop  in  1  downstream consumes out_data this cycle.
- gnt_id  out  $clog2(N_IN)  index of the last granted input.
- pkt_cnt  out  CNT_W  packets granted since reset; wraps modulo 2^CNT_W.
- stall_err  out  1  sticky watchdog flag.

Behaviour:
- Reset values (reset==0, async): out_pndng=0, out_data=0, in_pop=0, gnt_id=0, pkt_cnt=0, stall_err=0, stall counter=0, RR pointer=N_IN-1, so the first grant searches from input 0.
- Eligible set: req = in_pndng & ~in_mask.
- Grant condition per cycle: can_load = en & |req & (~out_pndng | out_pop).
- When can_load=1, the winner g is the first set bit of req searching circularly from pointer+1.
- in_pop is combinational: in_pop[g]=1 in the can_load cycle and 0 otherwise; never more than one bit set.
- At the next edge: out_data <= in_data[g], out_pndng <= 1, pointer <= g, gnt_id <= g, pkt_cnt++.
- Latency: pndng visible in cycle k gives in_pop in cycle k and out_pndng=1 from cycle k+1.
- Throughput: when out_pop and can_load coincide, the register reloads in the same edge with no bubble (1 packet/cycle).
- Drain: out_pop=1 and can_load=0 gives out_pndng <= 0 and leaves out_data unchanged.
- out_pop while out_pndng=0 is ignored.
- FSM, two states:
  - EMPTY (out_pndng=0): goes to FULL on can_load.
  - FULL (out_pndng=1): stays FULL on out_pop&can_load or on ~out_pop; goes to EMPTY on out_pop&~can_load.
- Masking or en=0 takes effect the same cycle it is applied. A packet already in the output register is unaffected.
- in_pndng dropping in the same cycle as a grant is not legal for a show-ahead FIFO. The arbiter samples in_data regardless.
- Watchdog: the counter increments each cycle with out_pndng&~out_pop and clears on out_pop or ~out_pndng.
  - Reaching STALL_TO sets stall_err, which is cleared only by reset.
  - The counter saturates at STALL_TO.
- Packet fields are passed through untouched. Broadcast (Nxtjp == {8{1'b1}}) gets no special priority.
- Reset mid-transfer discards the output register content. The in_pop of the reset cycle is forced to 0.

Decomposition:
- Shared package mesh_arb_pkg:
  - field-offset localparams NXTJP_MSB/LSB, ROW_MSB/LSB, COL_MSB/LSB, MODE_BIT, PAYLOAD_MSB, derived from pckg_sz;
  - the BDCST constant;
  - typedef enum {EMPTY, FULL} arb_state_e.
- Sub-module rr_arb_pick: combinational; inputs req[N_IN] and ptr; outputs one-hot gnt, gnt_idx and any. Implemented with a double-width rotate and priority encode.

Test Plan:
- Reset then single requester: in_pndng=5'b00100, in_data[2]=40'h00_2_0_8_00001, out_pop held 1 → in_pop=00100 in the same cycle; out_pndng=1 next cycle with out_data=40'h0020800001, gnt_id=2, pkt_cnt=1.
- All five pending continuously with out_pop=1 → grants in order 0,1,2,3,4,0 on consecutive cycles with no bubble; pkt_cnt=6 after six cycles.
- out_pop=0 with all pending → exactly one grant (input 0), then no in_pop while FULL. stall_err=1 after 64 stalled cycles and stays 1 after out_pop resumes.
- in_mask=5'b00011 with all pending → only inputs 2,3,4 are granted. Clearing the mask lets input 0 win next after input 4.
- en=0 while FULL and out_pop=1 → out_pndng falls next cycle and in_pop stays 0. en=1 resumes from pointer+1.
- Assert reset (0) mid-stream with out_pndng=1 → all outputs at reset values immediately (async). After release the first grant goes to the lowest pending index.
